noc_vc_bridge: RTL and testbench

//  Parametrised successor of the two-channel NoC bridge. It accepts one wormhole flit stream
//  (header/tail framed) and steers each whole packet onto one of NUM_VC virtual-channel senders.

---
 rtl/noc_vc_bridge_pkg.sv | 13 +
 rtl/noc_flit_fifo.sv | 50 +++++
 rtl/noc_vc_bridge.sv | 154 +++++++++++++++
 tb/tb_noc_vc_bridge.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_vc_bridge_pkg.sv
// Shared defaults and state encoding for the NoC virtual-channel bridge.
package noc_vc_bridge_pkg;

  localparam int NOC_DATA_WIDTH        = 32;
  localparam int NOC_VC_CHANNEL        = 2;
  localparam int NOC_BRIDGE_FIFO_DEPTH = 4;

  typedef enum logic {
    NOC_BR_IDLE = 1'b0,
    NOC_BR_BUSY = 1'b1
  } br_state_e;

endpackage

// File: rtl/noc_flit_fifo.sv
// Input elastic FIFO for framed flits; entry = {flit, header, tail}.
module noc_flit_fifo
  import noc_vc_bridge_pkg::*;
#(
  parameter int WIDTH = NOC_DATA_WIDTH + 2,
  parameter int DEPTH = NOC_BRIDGE_FIFO_DEPTH
) (
  input  logic             noc_clk,
  input  logic             noc_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  // Storage carries no reset; only pointers and occupancy are cleared.
  always_ff @(posedge noc_clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/noc_vc_bridge.sv
// Steers whole wormhole packets from one flit stream onto NUM_VC virtual-channel
// senders with a packet-atomic lock and fixed-priority or round-robin allocation.
module noc_vc_bridge
  import noc_vc_bridge_pkg::*;
#(
  parameter int  DATA_W     = NOC_DATA_WIDTH,
  parameter int  NUM_VC     = NOC_VC_CHANNEL,
  parameter int  FIFO_DEPTH = NOC_BRIDGE_FIFO_DEPTH,
  parameter int  RR_MODE    = 1,
  parameter int  ERR_W      = 8,
  localparam int VC_W       = $clog2(NUM_VC)
) (
  input  logic                     noc_clk,
  input  logic                     noc_rst,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  input  logic [DATA_W-1:0]        rx_flit,
  input  logic                     rx_is_header,
  input  logic                     rx_is_tail,
  output logic [NUM_VC-1:0]        vc_valid,
  input  logic [NUM_VC-1:0]        vc_ready,
  input  logic [NUM_VC-1:0]        vc_credit_ok,
  output logic [NUM_VC*DATA_W-1:0] vc_flit,
  output logic [NUM_VC-1:0]        vc_is_header,
  output logic [NUM_VC-1:0]        vc_is_tail,
  output logic                     busy,
  output logic [VC_W-1:0]          cur_vc,
  output logic [ERR_W-1:0]         err_cnt
);

  localparam int ENT_W = DATA_W + 2;

  logic [ENT_W-1:0]  fifo_din;
  logic [ENT_W-1:0]  hd_ent;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              hd_vld;
  logic              hd_hdr;
  logic              hd_tail;
  logic [DATA_W-1:0] hd_flit;

  br_state_e         state;
  logic [VC_W-1:0]   rr_ptr;
  logic [VC_W-1:0]   cur_vc_r;
  logic [ERR_W-1:0]  err_r;
  logic [VC_W-1:0]   grant;
  logic [VC_W-1:0]   sel_vc;
  logic              cand_any;
  logic              lane_en;
  logic              discard;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  function automatic logic [VC_W-1:0] next_vc(input logic [VC_W-1:0] v);
    return (v == VC_W'(NUM_VC - 1)) ? '0 : v + VC_W'(1);
  endfunction

  assign fifo_din = {rx_flit, rx_is_header, rx_is_tail};
  assign push     = rx_valid && rx_ready;
  assign rx_ready = !fifo_full;

  noc_flit_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .noc_clk (noc_clk),
    .noc_rst (noc_rst),
    .push    (push),
    .din     (fifo_din),
    .pop     (pop),
    .dout    (hd_ent),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign hd_vld  = !fifo_empty;
  assign hd_flit = hd_ent[ENT_W-1:2];
  assign hd_hdr  = hd_ent[1];
  assign hd_tail = hd_ent[0];

  // Search starts at rr_ptr in round-robin mode, at lane 0 for fixed priority.
  always_comb begin : grant_arb
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      idx = (RR_MODE != 0) ? int'(rr_ptr) + i : i;
      if (idx >= NUM_VC) idx = idx - NUM_VC;
      if (!found && vc_credit_ok[VC_W'(idx)]) begin
        grant = VC_W'(idx);
        found = 1'b1;
      end
    end
  end

  assign cand_any = |vc_credit_ok;
  assign sel_vc   = (state == NOC_BR_BUSY) ? cur_vc_r : grant;
  assign lane_en  = hd_vld && ((state == NOC_BR_BUSY) || (hd_hdr && cand_any));
  assign discard  = hd_vld && (state == NOC_BR_IDLE) && !hd_hdr;
  assign pop      = discard || (lane_en && vc_ready[sel_vc]);

  always_comb begin
    vc_valid     = '0;
    vc_is_header = '0;
    vc_is_tail   = '0;
    vc_flit      = '0;
    if (lane_en) begin
      vc_valid[sel_vc]                     = 1'b1;
      vc_is_header[sel_vc]                 = hd_hdr;
      vc_is_tail[sel_vc]                   = hd_tail;
      vc_flit[int'(sel_vc)*DATA_W +: DATA_W] = hd_flit;
    end
  end

  // Lock is taken on the header pop and released on the tail pop.
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state    <= NOC_BR_IDLE;
      rr_ptr   <= '0;
      cur_vc_r <= '0;
      err_r    <= '0;
    end else begin
      case (state)
        NOC_BR_IDLE: begin
          if (discard) begin
            err_r <= sat_inc(err_r);
          end else if (pop) begin
            cur_vc_r <= grant;
            rr_ptr   <= next_vc(grant);
            if (!hd_tail) state <= NOC_BR_BUSY;
          end
        end
        NOC_BR_BUSY: begin
          if (pop) begin
            if (hd_hdr)  err_r <= sat_inc(err_r);
            if (hd_tail) state <= NOC_BR_IDLE;
          end
        end
        default: state <= NOC_BR_IDLE;
      endcase
    end
  end

  assign busy    = (state == NOC_BR_BUSY);
  assign cur_vc  = cur_vc_r;
  assign err_cnt = err_r;

endmodule

// File: tb/tb_noc_vc_bridge.sv
// Scoreboard bench for noc_vc_bridge: packet-level reference model plus random traffic.
module tb_noc_vc_bridge;

  localparam int DW = 16;
  localparam int NV = 2;
  localparam int FD = 4;
  localparam int EW = 8;

  logic             noc_clk = 1'b0;
  logic             noc_rst = 1'b1;
  logic             rx_valid = 1'b0;
  logic             rx_ready;
  logic [DW-1:0]    rx_flit = '0;
  logic             rx_is_header = 1'b0;
  logic             rx_is_tail = 1'b0;
  logic [NV-1:0]    vc_valid;
  logic [NV-1:0]    vc_ready = '0;
  logic [NV-1:0]    vc_credit_ok = '0;
  logic [NV*DW-1:0] vc_flit;
  logic [NV-1:0]    vc_is_header;
  logic [NV-1:0]    vc_is_tail;
  logic             busy;
  logic [0:0]       cur_vc;
  logic [EW-1:0]    err_cnt;

  typedef struct {
    logic [DW-1:0] flit;
    logic          hdr;
    logic          tail;
  } ent_t;

  ent_t          q[$];
  int            total = 0;
  int            bad = 0;
  int            err_exp = 0;
  bit            in_pkt = 1'b0;
  int            m_busy = 0;
  int            m_vc = 0;
  int            m_rr = 0;
  bit            rnd_mode = 1'b0;
  logic [NV-1:0] dir_ready = '0;
  logic [NV-1:0] dir_credit = '0;

  always #5 noc_clk = ~noc_clk;

  noc_vc_bridge #(
    .DATA_W     (DW),
    .NUM_VC     (NV),
    .FIFO_DEPTH (FD),
    .RR_MODE    (1),
    .ERR_W      (EW)
  ) dut (
    .noc_clk      (noc_clk),
    .noc_rst      (noc_rst),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_flit      (rx_flit),
    .rx_is_header (rx_is_header),
    .rx_is_tail   (rx_is_tail),
    .vc_valid     (vc_valid),
    .vc_ready     (vc_ready),
    .vc_credit_ok (vc_credit_ok),
    .vc_flit      (vc_flit),
    .vc_is_header (vc_is_header),
    .vc_is_tail   (vc_is_tail),
    .busy         (busy),
    .cur_vc       (cur_vc),
    .err_cnt      (err_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // First VC with credit at or after the round-robin pointer; -1 when none.
  function automatic int rr_pick(input logic [NV-1:0] cr, input int rr);
    for (int k = 0; k < NV; k++) begin
      if (cr[(rr + k) % NV]) return (rr + k) % NV;
    end
    return -1;
  endfunction

  // Sink-side handshake driver: directed values or random back-pressure.
  initial begin
    forever begin
      @(posedge noc_clk);
      #2;
      if (rnd_mode) begin
        vc_ready     = NV'($urandom_range(0, 3));
        vc_credit_ok = ($urandom_range(0, 3) == 0) ? '0 : NV'($urandom_range(1, 3));
      end else begin
        vc_ready     = dir_ready;
        vc_credit_ok = dir_credit;
      end
    end
  end

  // Monitor: compares every presented flit against the scoreboard head.
  initial begin
    forever begin
      @(negedge noc_clk);
      if (noc_rst) begin
        q.delete();
        m_busy = 0;
        m_vc   = 0;
        m_rr   = 0;
      end else begin
        chk("busy", {31'd0, busy}, m_busy);
        if (m_busy != 0) chk("cur_vc", {31'd0, cur_vc}, m_vc);
        if (vc_valid != '0) begin
          int   lane;
          int   expv;
          ent_t e;
          lane = 0;
          for (int i = NV - 1; i >= 0; i--) if (vc_valid[i]) lane = i;
          chk("onehot", $countones(vc_valid), 1);
          if (q.size() == 0) begin
            chk("unexpected_flit", {30'd0, vc_valid}, 0);
          end else begin
            e    = q[0];
            expv = (m_busy != 0) ? m_vc : rr_pick(vc_credit_ok, m_rr);
            chk("lane", lane, expv);
            chk("flit", {16'd0, vc_flit[lane*DW +: DW]}, {16'd0, e.flit});
            chk("hdr", {31'd0, vc_is_header[lane]}, {31'd0, e.hdr});
            chk("tail", {31'd0, vc_is_tail[lane]}, {31'd0, e.tail});
            if (vc_ready[lane]) begin
              void'(q.pop_front());
              if (m_busy == 0) begin
                m_rr = (lane + 1) % NV;
                if (!e.tail) begin
                  m_busy = 1;
                  m_vc   = lane;
                end
              end else if (e.tail) begin
                m_busy = 0;
              end
            end
          end
        end
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [DW-1:0] f, input logic h, input logic t);
    bit ok;
    int n;
    rx_flit = f; rx_is_header = h; rx_is_tail = t; rx_valid = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 300) begin
      @(negedge noc_clk);
      ok = rx_ready;
      @(posedge noc_clk);
      n++;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout actual=stalled required=accept at %0t", $time);
    end else if (h) begin
      if (in_pkt) err_exp++;
      q.push_back('{f, h, t});
      in_pkt = !t;
    end else if (!in_pkt) begin
      err_exp++;
    end else begin
      q.push_back('{f, h, t});
      if (t) in_pkt = 1'b0;
    end
    #1 rx_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge noc_clk);
      n++;
    end
    chk("drain_left", q.size(), 0);
    repeat (3) @(posedge noc_clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge noc_clk);
    #1 noc_rst = 1'b0;
    chk("rst_vc_valid", {30'd0, vc_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_err", {24'd0, err_cnt}, 0);
    chk("rst_cur_vc", {31'd0, cur_vc}, 0);
    chk("rst_rx_ready", {31'd0, rx_ready}, 1);
    chk("rst_vc_flit", vc_flit, 0);

    // Three-flit packet, one-cycle latency to VC0
    dir_ready = 2'b11; dir_credit = 2'b11;
    @(posedge noc_clk); #1;
    send(16'hA001, 1'b1, 1'b0);
    chk("t1_latency", {30'd0, vc_valid}, 32'd1);
    send(16'hA002, 1'b0, 1'b0);
    send(16'hA003, 1'b0, 1'b1);
    drain();

    // Four single-flit packets alternate VCs
    for (int i = 0; i < 4; i++) send(16'hB000 + 16'(i), 1'b1, 1'b1);
    drain();

    // Credit vanishes after the header: packet finishes, next header stalls
    dir_credit = 2'b01;
    send(16'hC001, 1'b1, 1'b0);
    @(posedge noc_clk); #1;
    dir_credit = 2'b00;
    send(16'hC002, 1'b0, 1'b0);
    send(16'hC003, 1'b0, 1'b1);
    send(16'hC004, 1'b1, 1'b1);
    repeat (4) @(posedge noc_clk);
    #1;
    chk("t3_stall_valid", {30'd0, vc_valid}, 0);
    chk("t3_stall_busy", {31'd0, busy}, 0);
    dir_credit = 2'b01;
    drain();

    // Back-pressure fills the FIFO
    dir_ready = 2'b00;
    send(16'hD001, 1'b1, 1'b0);
    send(16'hD002, 1'b0, 1'b0);
    send(16'hD003, 1'b0, 1'b0);
    send(16'hD004, 1'b0, 1'b0);
    chk("t4_full", {31'd0, rx_ready}, 0);
    repeat (5) @(posedge noc_clk);
    #1;
    chk("t4_still_full", {31'd0, rx_ready}, 0);
    dir_ready = 2'b11;
    send(16'hD005, 1'b0, 1'b0);
    send(16'hD006, 1'b0, 1'b1);
    drain();

    // Protocol errors
    dir_credit = 2'b11;
    send(16'hE001, 1'b0, 1'b0);
    drain();
    chk("t5_err1", {24'd0, err_cnt}, err_exp);
    chk("t5_err1_abs", {24'd0, err_cnt}, 1);
    send(16'hE002, 1'b1, 1'b0);
    send(16'hE003, 1'b1, 1'b0);
    send(16'hE004, 1'b0, 1'b1);
    drain();
    chk("t5_err2", {24'd0, err_cnt}, err_exp);
    chk("t5_err2_abs", {24'd0, err_cnt}, 2);

    // Reset in the middle of a packet
    send(16'hF001, 1'b1, 1'b0);
    send(16'hF002, 1'b0, 1'b0);
    noc_rst = 1'b1;
    @(posedge noc_clk);
    #1 noc_rst = 1'b0;
    err_exp = 0;
    in_pkt  = 1'b0;
    chk("t6_vc_valid", {30'd0, vc_valid}, 0);
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_err", {24'd0, err_cnt}, 0);
    chk("t6_rx_ready", {31'd0, rx_ready}, 1);
    send(16'hF010, 1'b1, 1'b1);
    chk("t6_fresh_vc0", {30'd0, vc_valid}, 32'd1);
    drain();

    // Random traffic under random back-pressure and credit
    rnd_mode = 1'b1;
    for (int p = 0; p < 60; p++) begin
      int len;
      int gap;
      if ($urandom_range(0, 9) == 0) begin
        send(DW'($urandom), 1'b0, 1'b0);
      end else begin
        len = $urandom_range(1, 4);
        send(DW'($urandom), 1'b1, (len == 1));
        for (int b = 1; b < len - 1; b++)
          send(DW'($urandom), ($urandom_range(0, 14) == 0), 1'b0);
        if (len >= 2) send(DW'($urandom), 1'b0, 1'b1);
      end
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge noc_clk);
        #1;
      end
    end
    rnd_mode   = 1'b0;
    dir_ready  = 2'b11;
    dir_credit = 2'b11;
    drain();
    chk("rand_err", {24'd0, err_cnt}, err_exp);
    chk("rand_idle", {31'd0, busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
